decoder_onehot_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a built-in sweep sequencer. It decodes a SEL_W-bit code into an OUT_W-bit one-hot word. It can also step the active bit up or down at a programmable rate, which makes it the drive source for row/column strobes, channel-select lines and mux selects. It replaces fixed 4-to-16 shift decoders wherever a registered, handshaked or self-scanning select is needed.

---
 rtl/decoder_onehot_seq_pkg.sv | 28 ++
 rtl/decoder_onehot_seq_tick_div.sv | 28 ++
 rtl/decoder_onehot_seq.sv | 143 ++++++++++++++
 tb/tb_decoder_onehot_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/decoder_onehot_seq_pkg.sv
// Shared types and helpers for the one-hot decoder / sweep sequencer family.
package decoder_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    LOAD       = 2'b00,
    SWEEP_UP   = 2'b01,
    SWEEP_DOWN = 2'b10,
    HOLD       = 2'b11
  } mode_t;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    ACTIVE = ST_ACTIVE
  } dec_state_t;

  localparam int ONEHOT_MAX = 256;

  // Returns all-zero for an out-of-range code so callers never see multi-hot.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [31:0] code,
                                                   input logic [31:0] width);
    onehot = '0;
    if (code < width) onehot = ONEHOT_MAX'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_onehot_seq_tick_div.sv
// Free-running prescaler: tick marks the cycle where count equals div.
module tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic [DIV_W-1:0] count
);

  // A count already above a freshly lowered div runs to its maximum and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == div) count <= '0;
      else              count <= count + 1'b1;
    end
  end

  assign tick = ~rst & ~clr & en & (count == div);

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a LOAD handshake and up/down sweep.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int OUT_W = 2**SEL_W,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] q,
  output logic [SEL_W-1:0] sel_q,
  output logic             wrap,
  output logic             err,
  output dec_state_t       fsm_state,
  output logic [DIV_W-1:0] pre_count
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(OUT_W - 1);

  // Handshake: sel_in is consumed on any edge where sel_valid & sel_ready.
  mode_t            m;
  dec_state_t       state;
  logic [1:0]       mode_prev;
  logic             xfer;
  logic             sweep_run;
  logic             mode_chg;
  logic             div_clr;
  logic             tick;
  logic             sel_in_ok;
  logic [SEL_W-1:0] sel_entry;
  logic [SEL_W-1:0] sel_step;
  logic             wrap_now;
  logic [OUT_W-1:0] oh_load;
  logic [OUT_W-1:0] oh_entry;
  logic [OUT_W-1:0] oh_step;

  assign m         = mode_t'(mode);
  assign sel_ready = en & ~clr & ~rst & (m == LOAD);
  assign xfer      = sel_valid & sel_ready;
  assign mode_chg  = (mode != mode_prev);
  assign sweep_run = ((m == SWEEP_UP) || (m == SWEEP_DOWN)) && (state == ACTIVE);
  assign div_clr   = clr | (en & (mode_chg | ~sweep_run));

  assign sel_in_ok = 32'(sel_in) < 32'(OUT_W);
  assign sel_entry = (32'(sel_q) < 32'(OUT_W)) ? sel_q : '0;

  // Step arithmetic is modulo OUT_W, not modulo 2**SEL_W.
  always_comb begin
    sel_step = sel_q;
    wrap_now = 1'b0;
    if (m == SWEEP_DOWN) begin
      if (sel_q == '0) begin
        sel_step = SEL_LAST;
        wrap_now = 1'b1;
      end else begin
        sel_step = sel_q - 1'b1;
      end
    end else begin
      if (sel_q == SEL_LAST) begin
        sel_step = '0;
        wrap_now = 1'b1;
      end else begin
        sel_step = sel_q + 1'b1;
      end
    end
  end

  assign oh_load  = OUT_W'(onehot(32'(sel_in),   32'(OUT_W)));
  assign oh_entry = OUT_W'(onehot(32'(sel_entry), 32'(OUT_W)));
  assign oh_step  = OUT_W'(onehot(32'(sel_step),  32'(OUT_W)));

  tick_div #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (div_clr),
    .en    (en),
    .div   (div),
    .tick  (tick),
    .count (pre_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      sel_q     <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      mode_prev <= LOAD;
    end else if (clr) begin
      state     <= IDLE;
      q         <= '0;
      sel_q     <= '0;
      wrap      <= 1'b0;
      mode_prev <= LOAD;
    end else if (en) begin
      wrap      <= 1'b0;
      mode_prev <= mode;
      case (m)
        LOAD: begin
          if (xfer) begin
            sel_q <= sel_in;
            if (sel_in_ok) begin
              q     <= oh_load;
              state <= ACTIVE;
              err   <= 1'b0;
            end else begin
              q     <= '0;
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end
        SWEEP_UP, SWEEP_DOWN: begin
          if (state == IDLE) begin
            sel_q <= sel_entry;
            q     <= oh_entry;
            state <= ACTIVE;
          end else if (tick) begin
            sel_q <= sel_step;
            q     <= oh_step;
            wrap  <= wrap_now;
          end
        end
        HOLD: begin
        end
      endcase
    end else begin
      wrap <= 1'b0;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq (OUT_W=16 main instance, OUT_W=10 range instance).
module tb_decoder_onehot_seq;
  import decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, en, sel_valid;
  logic [1:0]  mode;
  logic [3:0]  sel_in;
  logic [7:0]  div;

  logic        sel_ready, wrap, err;
  logic [15:0] q;
  logic [3:0]  sel_q;
  dec_state_t  fsm_state;
  logic [7:0]  pre_count;

  logic        sel_ready10, wrap10, err10;
  logic [9:0]  q10;
  logic [3:0]  sel_q10;
  dec_state_t  fsm_state10;
  logic [7:0]  pre_count10;

  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(4), .OUT_W(16), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .div(div), .q(q), .sel_q(sel_q),
    .wrap(wrap), .err(err), .fsm_state(fsm_state), .pre_count(pre_count)
  );

  decoder_onehot_seq #(.SEL_W(4), .OUT_W(10), .DIV_W(8)) dut10 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready10), .div(div), .q(q10), .sel_q(sel_q10),
    .wrap(wrap10), .err(err10), .fsm_state(fsm_state10), .pre_count(pre_count10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic cyc(input logic [15:0] eq, input logic [3:0] es, input logic ew, input logic ee);
    logic [21:0] e;
    exp_q.push_back({eq, es, ew, ee});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("q",     32'(q),     32'(e[21:6]));
    chk("sel_q", 32'(sel_q), 32'(e[5:2]));
    chk("wrap",  32'(wrap),  32'(e[1]));
    chk("err",   32'(err),   32'(e[0]));
  endtask

  task automatic chk_ready(input logic exp);
    #1;
    chk("sel_ready", 32'(sel_ready), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; sel_valid = 1'b0;
    mode = LOAD; sel_in = 4'd0; div = 8'd0;

    // Reset and clear
    cyc(16'h0000, 4'd0, 1'b0, 1'b0);
    chk_ready(1'b0);
    cyc(16'h0000, 4'd0, 1'b0, 1'b0);
    chk("state_rst", 32'(fsm_state), 32'(ST_IDLE));
    rst = 1'b0; en = 1'b1; sel_in = 4'd5; sel_valid = 1'b1;
    chk_ready(1'b1);
    cyc(16'h0020, 4'd5, 1'b0, 1'b0);
    chk("state_load", 32'(fsm_state), 32'(ST_ACTIVE));
    clr = 1'b1; sel_valid = 1'b0;
    chk_ready(1'b0);
    cyc(16'h0000, 4'd0, 1'b0, 1'b0);
    clr = 1'b0;

    // Back-to-back loads, then en=0 freeze
    sel_valid = 1'b1;
    sel_in = 4'd0;  cyc(16'h0001, 4'd0,  1'b0, 1'b0);
    sel_in = 4'd15; cyc(16'h8000, 4'd15, 1'b0, 1'b0);
    sel_in = 4'd7;  cyc(16'h0080, 4'd7,  1'b0, 1'b0);
    en = 1'b0; sel_in = 4'd3;
    chk_ready(1'b0);
    cyc(16'h0080, 4'd7, 1'b0, 1'b0);
    cyc(16'h0080, 4'd7, 1'b0, 1'b0);
    en = 1'b1;
    cyc(16'h0008, 4'd3, 1'b0, 1'b0);
    sel_valid = 1'b0;
    cyc(16'h0008, 4'd3, 1'b0, 1'b0);

    // Range error on the OUT_W=10 instance; err sticky through clr
    sel_valid = 1'b1; sel_in = 4'd12;
    cyc(16'h1000, 4'd12, 1'b0, 1'b0);
    chk("r10_q",   32'(q10),     32'h000);
    chk("r10_sel", 32'(sel_q10), 32'd12);
    chk("r10_err", 32'(err10),   32'd1);
    chk("r10_st",  32'(fsm_state10), 32'(ST_IDLE));
    sel_valid = 1'b0; clr = 1'b1;
    cyc(16'h0000, 4'd0, 1'b0, 1'b0);
    chk("r10_clr_err", 32'(err10), 32'd1);
    chk("r10_clr_q",   32'(q10),   32'h000);
    clr = 1'b0; sel_valid = 1'b1; sel_in = 4'd3;
    cyc(16'h0008, 4'd3, 1'b0, 1'b0);
    chk("r10_q3",   32'(q10),   32'h008);
    chk("r10_err0", 32'(err10), 32'd0);

    // SWEEP_UP, div=2, from 14
    sel_in = 4'd14;
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    sel_valid = 1'b0; mode = SWEEP_UP; div = 8'd2;
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    chk("pre_entry", 32'(pre_count), 32'd0);
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    cyc(16'h8000, 4'd15, 1'b0, 1'b0);
    cyc(16'h8000, 4'd15, 1'b0, 1'b0);
    cyc(16'h8000, 4'd15, 1'b0, 1'b0);
    cyc(16'h0001, 4'd0,  1'b1, 1'b0);
    cyc(16'h0001, 4'd0,  1'b0, 1'b0);

    // SWEEP_DOWN, div=0, from 1; then HOLD clears the prescaler
    mode = LOAD; sel_valid = 1'b1; sel_in = 4'd1;
    cyc(16'h0002, 4'd1, 1'b0, 1'b0);
    sel_valid = 1'b0; mode = SWEEP_DOWN; div = 8'd0;
    cyc(16'h0002, 4'd1,  1'b0, 1'b0);
    cyc(16'h0001, 4'd0,  1'b0, 1'b0);
    cyc(16'h8000, 4'd15, 1'b1, 1'b0);
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    div = 8'd3;
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    chk("pre_before_hold", 32'(pre_count), 32'd2);
    mode = HOLD;
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    chk("pre_hold", 32'(pre_count), 32'd0);
    cyc(16'h4000, 4'd14, 1'b0, 1'b0);

    // div lowered 5 -> 1 with prescaler at 3: must roll over before matching
    mode = SWEEP_UP; div = 8'd5;
    for (int i = 0; i < 4; i++) cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    chk("pre_at3", 32'(pre_count), 32'd3);
    div = 8'd1;
    for (int i = 0; i < 254; i++) cyc(16'h4000, 4'd14, 1'b0, 1'b0);
    chk("pre_rolled", 32'(pre_count), 32'd1);
    cyc(16'h8000, 4'd15, 1'b0, 1'b0);
    cyc(16'h8000, 4'd15, 1'b0, 1'b0);

    // rst on the edge that would wrap: no pulse, q cleared
    rst = 1'b1;
    cyc(16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(16'h0001, 4'd0, 1'b0, 1'b0);
    cyc(16'h0001, 4'd0, 1'b0, 1'b0);
    cyc(16'h0002, 4'd1, 1'b0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
